spi_aes_slave: RTL and testbench
================================

Name: spi_aes_slave

Overview:
- SPI slave endpoint for the AES core; the counterpart of the AES SPI master.
- Receives command, plaintext/ciphertext and key frames from the master over SPI mode 0. Launches the AES core with a one-cycle start pulse.
- Captures the core result and returns it, with a status byte, on a later READ frame.
- Fully synchronous to the local system clock; SPI pins are oversampled.

Parameters:
- NK, 4, key length in 32-bit words; KEY_W = 32*NK (localparam).
- FRAME_KEY, derived: 8+128+KEY_W bits (264 at NK=4), length of ENC/DEC frames.
- FRAME_RD, 136, length of a READ frame (8+128).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from master, asynchronous; period >= 8 clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first; 0 when cs_n high.
- core_start  out  1  one-clk pulse that launches the AES core.
- core_sel_encrypt  out  1  high for ENC command; held until next start.
- core_sel_decrypt  out  1  high for DEC command; held until next start.
- core_data  out  128  data block for the core.
- core_key  out  KEY_W  key for the core.
- core_done  in  1  one-clk pulse from the core; core_result is valid in that cycle.
- core_result  in  128  core output block.
- frame_err  out  1  one-clk pulse when a frame is rejected.

Behaviour:
- Reset: all outputs 0; busy=0, result_valid=0, result_reg=0, bit counter=0, FSM=IDLE.
- Synchronisation:
  - sclk and cs_n each pass through 2 flops, then a registered edge detect; mosi passes through 2 flops.
  - Edge events therefore act 3 clk after the pin change.
- SPI mode 0: sample mosi on synced sclk rise; update miso on synced sclk fall.
- FSM states: IDLE, SHIFT, EVAL.
  - IDLE -> SHIFT on synced cs_n fall. On entry: clear bit counter and rx shift register; load tx register = {status, result_reg}.
    - Status byte: bit7 = result_valid, bit6 = busy, bits5:0 = 0.
    - miso drives tx bit 135 immediately.
  - SHIFT: on each sclk rise, shift mosi into rx register (LSB in) and increment the counter. The counter saturates at 511 and never wraps.
  - SHIFT: on each sclk fall, shift the tx register left and drive the new MSB on miso. Once 136 bits are shifted out, miso=0.
  - SHIFT -> EVAL on synced cs_n rise.
- EVAL (one cycle) -> IDLE. cmd = first 8 bits received.
  - cmd 8'h01 (ENC) or 8'h02 (DEC), count==FRAME_KEY, busy=0: on the next clk, pulse core_start, set busy, and load core_data, core_key and the sel lines. core_start therefore rises 4 clk after the cs_n rise is sampled.
  - cmd 8'h03 (READ), count==FRAME_RD: clear result_valid if it was 1. The result is shifted out regardless of result_valid.
  - Any other case: pulse frame_err, no start, no state change. This covers a wrong count, an unknown cmd, and ENC/DEC while busy.
- core_done: result_reg <= core_result, result_valid <= 1, busy <= 0.
  - If core_done coincides with a READ clear in EVAL, core_done wins: valid=1.
  - A new result overwrites an unread one.
- A cs_n glitch shorter than 2 clk may be missed; no requirement on it.
- rst mid-frame: all state cleared. If cs_n is still low after rst deasserts, the FSM stays IDLE until a fresh synced cs_n fall. The partial frame never produces a start.
- sclk edges while cs_n high are ignored.

Decomposition:
- Shared package/include `aes_spi_defs`:
  - CMD_ENC=8'h01, CMD_DEC=8'h02, CMD_READ=8'h03.
  - STAT_VALID=7, STAT_BUSY=6.
  - Frame-length constants, shared with the master.
- Sub-module `spi_sync_edge`: 2-flop synchroniser plus registered rise/fall pulses. Instantiated for sclk and cs_n.

Test Plan:
1. ENC frame, cmd 01, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, 264 bits. Required: exactly one core_start, core_sel_encrypt=1, core_sel_decrypt=0, data/key match, frame_err=0.
2. core_done with result 69c4e0d86a7b0430d8cdb78070b4c55a, then a 136-bit READ frame. Required: miso yields 0x80 followed by the result MSB first. A second READ yields status 0x00.
3. DEC frame sent before core_done from scenario 1. Required: no core_start, one frame_err pulse, sel lines unchanged. A READ during busy shows status 0x40.
4. ENC frame cut off at 200 bits. Required: frame_err pulse, no start. Same with 265 bits: frame_err.
5. rst asserted at bit 100 of an ENC frame, released with cs_n still low, frame completed. Required: outputs 0, no start. The next full ENC frame starts normally.
6. cmd 7F with 264 bits. Required: frame_err and no start. core_done coincident with a READ EVAL leaves result_valid=1.

Source files
------------

// File: rtl/aes_spi_defs.sv
// Shared constants for the AES SPI link (master and slave).
// Commands, status bit positions, frame lengths, FSM encoding.
package aes_spi_defs;

    localparam logic [7:0] CMD_ENC  = 8'h01;
    localparam logic [7:0] CMD_DEC  = 8'h02;
    localparam logic [7:0] CMD_READ = 8'h03;

    localparam int STAT_VALID = 7;
    localparam int STAT_BUSY  = 6;

    localparam int CMD_W    = 8;
    localparam int BLOCK_W  = 128;
    localparam int FRAME_RD = CMD_W + BLOCK_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EVAL
    } slave_state_e;

    // ENC/DEC frame length for a key of nk 32-bit words.
    function automatic int frame_key_len(input int nk);
        return CMD_W + BLOCK_W + 32 * nk;
    endfunction

    function automatic logic [7:0] status_byte(input logic valid,
                                               input logic busy);
        logic [7:0] s;
        s = 8'h00;
        s[STAT_VALID] = valid;
        s[STAT_BUSY]  = busy;
        return s;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses.
// Ports: clk, rst, async_i (pin), rise_o/fall_o (one-clk pulses).
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       rise_q;
    logic       fall_q;

    // Reset to 0: a chip select held low through reset must not
    // look like a fresh falling edge afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
            rise_q <= sync_q[1] & ~prev_q;
            fall_q <= ~sync_q[1] & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_aes_slave.sv
// SPI mode-0 slave front end for the AES core.
// Ports: SPI pins (sclk, cs_n, mosi, miso), core launch
// (core_start, core_sel_*, core_data, core_key), core result
// (core_done, core_result) and frame_err.
module spi_aes_slave
    import aes_spi_defs::*;
#(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              core_start,
    output logic              core_sel_encrypt,
    output logic              core_sel_decrypt,
    output logic [127:0]      core_data,
    output logic [32*NK-1:0]  core_key,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic              frame_err
);

    localparam int KEY_W     = 32 * NK;
    localparam int FRAME_KEY = frame_key_len(NK);
    localparam int RX_W      = BLOCK_W + KEY_W;
    localparam int TX_W      = FRAME_RD;

    localparam logic [8:0] CNT_KEY = 9'(FRAME_KEY);
    localparam logic [8:0] CNT_RD  = 9'(FRAME_RD);
    localparam logic [8:0] CNT_CMD = 9'(CMD_W);
    localparam logic [8:0] CNT_MAX = 9'd511;

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .async_i (sclk),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk     (clk),
        .rst     (rst),
        .async_i (cs_n),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    slave_state_e      state_q;
    logic              mosi_q1;
    logic              mosi_q2;
    logic [8:0]        cnt_q;
    logic [7:0]        cmd_q;
    logic [RX_W-1:0]   rx_q;
    logic [TX_W-1:0]   tx_q;
    logic              miso_q;
    logic              busy_q;
    logic              valid_q;
    logic [127:0]      result_q;
    logic              start_q;
    logic              enc_q;
    logic              dec_q;
    logic [127:0]      data_q;
    logic [KEY_W-1:0]  key_q;
    logic              err_q;

    logic is_core_cmd;
    assign is_core_cmd = (cmd_q == CMD_ENC) || (cmd_q == CMD_DEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mosi_q1  <= 1'b0;
            mosi_q2  <= 1'b0;
            cnt_q    <= '0;
            cmd_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            start_q  <= 1'b0;
            enc_q    <= 1'b0;
            dec_q    <= 1'b0;
            data_q   <= '0;
            key_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            mosi_q1 <= mosi;
            mosi_q2 <= mosi_q1;
            start_q <= 1'b0;
            err_q   <= 1'b0;

            if (core_done) begin
                result_q <= core_result;
                valid_q  <= 1'b1;
                busy_q   <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                        cmd_q   <= '0;
                        rx_q    <= '0;
                        tx_q    <= {status_byte(valid_q, busy_q), result_q};
                        miso_q  <= valid_q;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_q <= {rx_q[RX_W-2:0], mosi_q2};
                        // The command is the first byte; the rx
                        // register only keeps the trailing data+key.
                        if (cnt_q < CNT_CMD) begin
                            cmd_q <= {cmd_q[6:0], mosi_q2};
                        end
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 9'd1;
                        end
                    end
                    // Zero fill makes miso fall to 0 after 136 bits.
                    if (sclk_fall) begin
                        tx_q   <= {tx_q[TX_W-2:0], 1'b0};
                        miso_q <= tx_q[TX_W-2];
                    end
                    if (cs_rise) begin
                        state_q <= ST_EVAL;
                        miso_q  <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    state_q <= ST_IDLE;
                    if (is_core_cmd && cnt_q == CNT_KEY && !busy_q) begin
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        enc_q   <= (cmd_q == CMD_ENC);
                        dec_q   <= (cmd_q == CMD_DEC);
                        data_q  <= rx_q[RX_W-1:KEY_W];
                        key_q   <= rx_q[KEY_W-1:0];
                    end else if (cmd_q == CMD_READ && cnt_q == CNT_RD) begin
                        // A result landing in this cycle stays valid.
                        if (!core_done) begin
                            valid_q <= 1'b0;
                        end
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso             = miso_q;
    assign core_start       = start_q;
    assign core_sel_encrypt = enc_q;
    assign core_sel_decrypt = dec_q;
    assign core_data        = data_q;
    assign core_key         = key_q;
    assign frame_err        = err_q;

endmodule

// File: tb/tb_spi_aes_slave.sv
// Self-checking bench for spi_aes_slave with a frame-level model.
// Drives SPI mode-0 frames and checks core launch and READ replies.
module tb_spi_aes_slave;

    localparam int KEY_W = 128;
    localparam int HALF  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             sclk;
    logic             cs_n;
    logic             mosi;
    logic             miso;
    logic             core_start;
    logic             core_sel_encrypt;
    logic             core_sel_decrypt;
    logic [127:0]     core_data;
    logic [KEY_W-1:0] core_key;
    logic             core_done;
    logic [127:0]     core_result;
    logic             frame_err;

    spi_aes_slave #(.NK(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .sclk             (sclk),
        .cs_n             (cs_n),
        .mosi             (mosi),
        .miso             (miso),
        .core_start       (core_start),
        .core_sel_encrypt (core_sel_encrypt),
        .core_sel_decrypt (core_sel_decrypt),
        .core_data        (core_data),
        .core_key         (core_key),
        .core_done        (core_done),
        .core_result      (core_result),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (core_start === 1'b1) start_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    // Frame-level model of the slave.
    bit           m_busy;
    bit           m_valid;
    logic [127:0] m_result;
    bit           m_enc;
    bit           m_dec;
    logic [127:0] m_data;
    logic [127:0] m_key;

    function automatic void model_reset();
        m_busy = 0; m_valid = 0; m_result = '0;
        m_enc = 0; m_dec = 0; m_data = '0; m_key = '0;
    endfunction

    function automatic void model_frame(input logic [7:0] cmd, input int n,
                                        input logic [127:0] d,
                                        input logic [127:0] k,
                                        input bit done_same,
                                        output bit exp_start,
                                        output bit exp_err);
        exp_start = 0;
        exp_err = 0;
        if ((cmd == 8'h01 || cmd == 8'h02) && n == 264 && !m_busy) begin
            exp_start = 1;
            m_busy = 1;
            m_enc = (cmd == 8'h01);
            m_dec = (cmd == 8'h02);
            m_data = d;
            m_key = k;
        end else if (cmd == 8'h03 && n == 136) begin
            if (!done_same) m_valid = 0;
        end else begin
            exp_err = 1;
        end
    endfunction

    function automatic logic [135:0] model_reply();
        return {m_valid, m_busy, 6'b0, m_result};
    endfunction

    // n bits sent MSB first from tx[n-1]; miso collected into rx.
    task automatic spi_xfer(input logic [299:0] tx, input int n,
                            input int rst_at, input bit done_eval,
                            input logic [127:0] done_val,
                            output logic [299:0] rx);
        rx = '0;
        @(negedge clk);
        mosi = tx[n-1];
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (3) @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
            end
            rx = {rx[298:0], miso};
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            mosi = (i + 1 < n) ? tx[n-2-i] : 1'b0;
            repeat (HALF) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        if (done_eval) begin
            core_result = done_val;
            repeat (4) @(posedge clk);
            @(negedge clk);
            core_done = 1'b1;
            @(negedge clk);
            core_done = 1'b0;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic pulse_done(input logic [127:0] r);
        @(negedge clk);
        core_result = r;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        m_result = r;
        m_valid = 1;
        m_busy = 0;
        repeat (2) @(negedge clk);
    endtask

    // Sends a 264-bit core frame and checks launch outputs.
    task automatic core_frame(input string nm, input logic [7:0] cmd,
                              input logic [127:0] d,
                              input logic [127:0] k);
        logic [299:0] tx;
        logic [299:0] rx;
        int s0;
        int e0;
        bit es;
        bit ee;
        tx = '0;
        tx[263:0] = {cmd, d, k};
        s0 = start_cnt;
        e0 = err_cnt;
        spi_xfer(tx, 264, -1, 0, '0, rx);
        model_frame(cmd, 264, d, k, 0, es, ee);
        checks++;
        if (start_cnt - s0 !== int'(es)) begin
            errors++;
            $display("FAIL %s start: got %0d want %0d", nm, start_cnt - s0, es);
        end
        checks++;
        if (err_cnt - e0 !== int'(ee)) begin
            errors++;
            $display("FAIL %s frame_err: got %0d want %0d", nm, err_cnt - e0, ee);
        end
        checks++;
        if (core_sel_encrypt !== m_enc || core_sel_decrypt !== m_dec) begin
            errors++;
            $display("FAIL %s sel: got %b%b want %b%b", nm, core_sel_encrypt,
                     core_sel_decrypt, m_enc, m_dec);
        end
        checks++;
        if (core_data !== m_data || core_key !== m_key) begin
            errors++;
            $display("FAIL %s data/key: got %h/%h want %h/%h", nm, core_data,
                     core_key, m_data, m_key);
        end
    endtask

    task automatic read_frame(input string nm, input bit done_eval,
                              input logic [127:0] done_val);
        logic [299:0] tx;
        logic [299:0] rx;
        logic [135:0] want;
        int e0;
        bit es;
        bit ee;
        tx = '0;
        tx[135:128] = 8'h03;
        want = model_reply();
        e0 = err_cnt;
        spi_xfer(tx, 136, -1, done_eval, done_val, rx);
        model_frame(8'h03, 136, '0, '0, done_eval, es, ee);
        if (done_eval) begin
            m_result = done_val;
            m_valid = 1;
            m_busy = 0;
        end
        checks++;
        if (rx[135:0] !== want) begin
            errors++;
            $display("FAIL %s reply: got %h want %h", nm, rx[135:0], want);
        end
        checks++;
        if (err_cnt - e0 !== int'(ee)) begin
            errors++;
            $display("FAIL %s frame_err: got %0d want %0d", nm, err_cnt - e0, ee);
        end
    endtask

    task automatic bad_frame(input string nm, input logic [299:0] tx,
                             input int n);
        logic [299:0] rx;
        int s0;
        int e0;
        s0 = start_cnt;
        e0 = err_cnt;
        spi_xfer(tx, n, -1, 0, '0, rx);
        checks++;
        if (start_cnt != s0 || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL %s: got start %0d err %0d want start 0 err 1", nm,
                     start_cnt - s0, err_cnt - e0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        checks++;
        if ({miso, core_start, core_sel_encrypt, core_sel_decrypt, frame_err}
            !== 5'b0) begin
            errors++;
            $display("FAIL reset ctl: got %b want 00000", {miso, core_start,
                     core_sel_encrypt, core_sel_decrypt, frame_err});
        end
        checks++;
        if (core_data !== '0 || core_key !== '0) begin
            errors++;
            $display("FAIL reset data: got %h/%h want 0", core_data, core_key);
        end
    endtask

    task automatic test_enc();
        core_frame("enc", 8'h01, 128'h00112233445566778899aabbccddeeff,
                   128'h000102030405060708090a0b0c0d0e0f);
    endtask

    task automatic test_busy();
        core_frame("dec_busy", 8'h02, {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom});
        read_frame("read_busy", 0, '0);
    endtask

    task automatic test_read();
        pulse_done(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        read_frame("read1", 0, '0);
        read_frame("read2", 0, '0);
    endtask

    task automatic test_bad_len();
        logic [263:0] f;
        logic [299:0] tx;
        f = {8'h01, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
        tx = '0;
        tx[199:0] = f[263:64];
        bad_frame("len200", tx, 200);
        tx = '0;
        tx[264:0] = {f, 1'b1};
        bad_frame("len265", tx, 265);
    endtask

    task automatic test_rst_mid();
        logic [299:0] tx;
        logic [299:0] rx;
        int s0;
        int e0;
        tx = '0;
        tx[263:0] = {8'h01, 128'h00112233445566778899aabbccddeeff,
                     128'h000102030405060708090a0b0c0d0e0f};
        s0 = start_cnt;
        e0 = err_cnt;
        spi_xfer(tx, 264, 100, 0, '0, rx);
        model_reset();
        checks++;
        if (start_cnt != s0 || err_cnt != e0) begin
            errors++;
            $display("FAIL rst_mid pulses: got start %0d err %0d want 0 0",
                     start_cnt - s0, err_cnt - e0);
        end
        checks++;
        if (core_data !== '0 || core_key !== '0 || core_sel_encrypt !== 1'b0
            || core_sel_decrypt !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid outputs: got %h/%h/%b%b want 0", core_data,
                     core_key, core_sel_encrypt, core_sel_decrypt);
        end
        core_frame("enc_after_rst", 8'h01,
                   {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom});
        pulse_done({$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_bad_cmd();
        logic [299:0] tx;
        tx = '0;
        tx[263:0] = {8'h7f, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
        bad_frame("cmd7f", tx, 264);
    endtask

    task automatic test_done_read();
        read_frame("read_done_eval", 1,
                   {$urandom, $urandom, $urandom, $urandom});
        read_frame("read_after_coincide", 0, '0);
        read_frame("read_cleared", 0, '0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            core_frame("b2b", ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h02,
                       {$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom});
            pulse_done({$urandom, $urandom, $urandom, $urandom});
            read_frame("b2b_read", 0, '0);
        end
    endtask

    initial begin
        rst = 1'b0;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        core_done = 1'b0;
        core_result = '0;
        test_reset();
        test_enc();
        test_busy();
        test_read();
        test_bad_len();
        test_rst_mid();
        test_bad_cmd();
        test_done_read();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
